seven_seg_capture: RTL

SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

---
 rtl/seven_seg_capture_pkg.sv | 21 ++
 rtl/seven_seg_pattern_decode.sv | 22 ++
 rtl/seven_seg_capture.sv | 119 +++++++++++
 3 files changed

// File: rtl/seven_seg_capture_pkg.sv
// Shared seven-segment definitions: segment patterns (bit0=a .. bit6=g),
// the nibble reported for unrecognised patterns, and capture FSM states.
package seven_seg_capture_pkg;

    localparam logic [6:0] SEG_PATTERNS [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [3:0] NIBBLE_INVALID = 4'h0;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } cap_state_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_PATTERNS[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational inverse of the shared hex-to-segment table; any pattern not
// in the table is flagged invalid and reported as NIBBLE_INVALID.
module seven_seg_pattern_decode
    import seven_seg_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        nibble  = NIBBLE_INVALID;
        invalid = 1'b1;
        for (int unsigned i = 0; i < 16; i++) begin
            if (pattern == SEG_PATTERNS[i]) begin
                nibble  = 4'(i);
                invalid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed seven-segment display into per-digit nibbles once
// each digit's inputs have been stable long enough, then holds the frame.
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter bit          INVERT_INPUT  = 1'b0,
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    error
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [6:0]            prev_seg;
    logic [NUM_DIGITS-1:0] prev_sel;
    logic [7:0]            stable_cnt;
    logic [6:0]            seg_eff;
    logic [3:0]            dec_nibble;
    logic                  dec_invalid;
    logic                  changed;
    logic                  stable_hit;
    logic                  capture;
    logic                  capture_en;
    logic                  accept;
    cap_state_t            state;
    cap_state_t            state_next;

    assign seg_eff = INVERT_INPUT ? ~seg_in : seg_in;

    seven_seg_pattern_decode u_decode (
        .pattern (seg_eff),
        .nibble  (dec_nibble),
        .invalid (dec_invalid)
    );

    assign changed = (seg_in != prev_seg) || (digit_sel != prev_sel);
    // Fires only on the step into saturation, so one capture per stable period;
    // a period completing while captures are disabled is simply lost.
    assign stable_hit = !changed && (stable_cnt == CNT_MAX - 8'd1);
    assign capture    = stable_hit && capture_en && $onehot(digit_sel);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_seg   <= '0;
            prev_sel   <= '0;
            stable_cnt <= '0;
        end else begin
            prev_seg <= seg_in;
            prev_sel <= digit_sel;
            if (changed) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        capture_en  = 1'b0;
        accept      = 1'b0;
        frame_valid = 1'b0;
        case (state)
            COLLECT: begin
                capture_en = 1'b1;
                if (&digit_valid) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                frame_valid = 1'b1;
                if (frame_ready) begin
                    accept     = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hex_out     <= '0;
            digit_valid <= '0;
            error       <= 1'b0;
        end else if (accept) begin
            digit_valid <= '0;
            error       <= 1'b0;
        end else if (capture) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (digit_sel[i]) begin
                    hex_out[4*i +: 4] <= dec_nibble;
                    digit_valid[i]    <= 1'b1;
                end
            end
            if (dec_invalid) begin
                error <= 1'b1;
            end
        end
    end

endmodule
